dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Two-port arbiter and sequencer for the 64-word data memory (combinational read, clocked word write). Port 0 is the core load/store unit; port 1 is the debug/DMA loader. Round-robin arbitration selects one requester per transaction. Byte-enabled stores become a read-modify-write sequence, because the memory only writes whole words.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in the memory; valid word index 0..DEPTH_WORDS-1.
RESET_PRIO, 0, port holding round-robin priority after reset (0 or 1).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
p0_valid / p1_valid  input  1  request valid, held until accepted.
p0_ready / p1_ready  output  1  request accepted this cycle (valid & ready).
p0_we / p1_we  input  1  1 = store, 0 = load.
p0_addr / p1_addr  input  32  byte address; bits [1:0] ignored.
p0_wdata / p1_wdata  input  32  store data, in word lanes.
p0_be / p1_be  input  4  byte enables; bit i covers wdata[8i+7:8i].
p0_resp_valid / p1_resp_valid  output  1  one-cycle completion pulse to the owning port.
resp_rdata  output  32  load data; valid with a resp_valid pulse, 0 for stores.
resp_err  output  1  out-of-range flag, valid with a resp_valid pulse.
busy  output  1  high in any state other than IDLE.
dm_mem_write  output  1  memory write strobe.
dm_addr  output  32  memory byte address, {word_index, 2'b00}.
dm_wdata  output  32  memory write data.
dm_rdata  input  32  memory combinational read data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; rr pointer=RESET_PRIO; latched command cleared. Reset mid-sequence aborts the transaction: no write is issued, no response is sent, memory contents are untouched.
- States: IDLE, EXEC, MERGE_WR, RESP.
- IDLE: pN_ready is combinational, high only for the granted port.
  - One port valid: that port is granted.
  - Both ports valid: the port at the rr pointer is granted.
  - On accept: latch port id, we, word index (addr[31:2]), wdata and be; rr pointer moves to the other port; go to EXEC.
  - Ready is never high outside IDLE.
- EXEC: dm_addr driven from the latched index.
  - Load: register dm_rdata into resp_rdata; go to RESP.
  - Store with be=4'hF: dm_mem_write=1, dm_wdata=wdata; go to RESP.
  - Store with be=0: no write; go to RESP.
  - Other be: merge register = per byte (be ? wdata : dm_rdata); go to MERGE_WR.
- MERGE_WR: dm_mem_write=1, dm_wdata=merge register; go to RESP.
- RESP: owner's resp_valid=1 for exactly one cycle; go to IDLE.
  - A new accept can occur in the following IDLE cycle.
- dm_mem_write is only ever high in EXEC or MERGE_WR.
- Latency from the accept cycle N: resp_valid at N+2 for a load, a full store or a be=0 store; N+3 for a partial store.
- dm_addr outside EXEC and MERGE_WR: holds the last latched index.
- Wrap-around: the word index is the latched addr[31:2] reduced modulo DEPTH_WORDS.

Optional Feature:
DMEM_CTRL_RANGE_CHK_EN
- Defined: if addr[31:2] >= DEPTH_WORDS, EXEC issues no write and no merge, resp_rdata=0, resp_err=1 at RESP; latency N+2 for every case.
- Undefined: no check; index wraps modulo DEPTH_WORDS; resp_err is tied to 0.

Decomposition:
- Shared package dmem_pkg: state enum (IDLE/EXEC/MERGE_WR/RESP), BE_FULL=4'hF, WORD_W=32, and the function used for the byte merge.
- One natural sub-module: dmem_rr_arb (two-way round-robin grant with priority pointer, reset to RESET_PRIO). The FSM and datapath stay in dmem_ctrl.

Test Plan:
- Word 3=0; p0 store addr 0x0C, wdata 0xDEADBEEF, be 4'hF; p0 load 0x0C → p0_resp_valid at N+2, resp_rdata=0xDEADBEEF.
- Word 5=0x11223344; p1 store addr 0x14, wdata 0xAABBCCDD, be 4'b0101 → single write at N+2, word=0x11BB33DD, p1_resp_valid at N+3.
- RESET_PRIO=0, both ports valid continuously for 4 transactions → grants p0,p1,p0,p1; ready never high on both ports; every resp_valid goes to the correct port.
- Store with be=0 → dm_mem_write never asserted; resp_valid at N+2.
- rst_n dropped during MERGE_WR → no dm_mem_write, no resp_valid, state IDLE, rr=RESET_PRIO, target word unchanged.
- With DMEM_CTRL_RANGE_CHK_EN: store to 0x100 (index 64) → no write, resp_err=1, resp_rdata=0 at N+2; without the macro, word 0 is written instead.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the two-port data-memory controller.
package dmem_pkg;
  localparam int         WORD_W  = 32;
  localparam logic [3:0] BE_FULL = 4'hF;

  typedef enum logic [1:0] {IDLE, EXEC, MERGE_WR, RESP} state_e;

  function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] wdata,
                                                   input logic [WORD_W-1:0] rdata,
                                                   input logic [3:0]        be);
    logic [WORD_W-1:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? wdata[8*b +: 8] : rdata[8*b +: 8];
    return m;
  endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle for the two requesters (port 0 = LSU, port 1 = debug/DMA).
interface dmem_ctrl_if;
  logic        p0_valid, p0_ready, p0_we, p0_resp_valid;
  logic [31:0] p0_addr, p0_wdata;
  logic [3:0]  p0_be;
  logic        p1_valid, p1_ready, p1_we, p1_resp_valid;
  logic [31:0] p1_addr, p1_wdata;
  logic [3:0]  p1_be;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata, p0_be,
    output p1_valid, p1_we, p1_addr, p1_wdata, p1_be,
    input  p0_ready, p1_ready, p0_resp_valid, p1_resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata, p0_be,
    input  p1_valid, p1_we, p1_addr, p1_wdata, p1_be,
    output p0_ready, p1_ready, p0_resp_valid, p1_resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin grant; the pointer names the port that wins a tie.
module dmem_rr_arb #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);
  logic ptr_q;

  always_comb begin
    gnt_id_o = ptr_q;
    if (req_i == 2'b01)      gnt_id_o = 1'b0;
    else if (req_i == 2'b10) gnt_id_o = 1'b1;
    gnt_o = '0;
    if (|req_i) gnt_o[gnt_id_o] = 1'b1;
  end

  // After any grant the other port takes priority.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     ptr_q <= RESET_PRIO;
    else if (adv_i) ptr_q <= ~gnt_id_o;
endmodule

// File: rtl/dmem_ctrl.sv
// Two-port arbiter/sequencer for the word-write data memory; partial stores run as RMW.
// Optional: define DMEM_CTRL_RANGE_CHK_EN to reject word indices >= DEPTH_WORDS.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int RESET_PRIO  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus,
  output logic        busy,
  output logic        dm_mem_write,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e             state_q;
  logic [1:0]         req, gnt, rvld_q;
  logic               gid, accept;
  logic               sel_we, sel_err;
  logic [29:0]        sel_word;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_be;
  logic [IDX_W-1:0]   sel_idx, idx_q;
  logic               own_q, we_q, err_q, dm_we_q;
  logic [3:0]         be_q;
  logic [WORD_W-1:0]  dm_wdata_q, rdata_q;

  assign req    = {bus.p1_valid, bus.p0_valid};
  assign accept = (state_q == IDLE) && (|req);

  dmem_rr_arb #(.RESET_PRIO(RESET_PRIO != 0)) u_arb (
    .clk(clk), .rst_n(rst_n), .req_i(req), .adv_i(accept), .gnt_o(gnt), .gnt_id_o(gid)
  );

  assign bus.p0_ready = (state_q == IDLE) & gnt[0];
  assign bus.p1_ready = (state_q == IDLE) & gnt[1];

  assign sel_we    = gid ? bus.p1_we          : bus.p0_we;
  assign sel_word  = gid ? bus.p1_addr[31:2]  : bus.p0_addr[31:2];
  assign sel_wdata = gid ? bus.p1_wdata       : bus.p0_wdata;
  assign sel_be    = gid ? bus.p1_be          : bus.p0_be;
  assign sel_idx   = IDX_W'({2'b00, sel_word} % 32'(DEPTH_WORDS));
`ifdef DMEM_CTRL_RANGE_CHK_EN
  assign sel_err   = ({2'b00, sel_word} >= 32'(DEPTH_WORDS));
`else
  assign sel_err   = 1'b0;
`endif

  // dm_wdata_q doubles as the latched store data until the merge overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      own_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      be_q       <= '0;
      idx_q      <= '0;
      dm_we_q    <= 1'b0;
      dm_wdata_q <= '0;
      rdata_q    <= '0;
      rvld_q     <= '0;
    end else begin
      dm_we_q <= 1'b0;
      rvld_q  <= '0;
      case (state_q)
        IDLE: if (accept) begin
          own_q      <= gid;
          we_q       <= sel_we;
          err_q      <= sel_err;
          be_q       <= sel_be;
          idx_q      <= sel_idx;
          dm_wdata_q <= sel_wdata;
          dm_we_q    <= sel_we && (sel_be == BE_FULL) && !sel_err;
          state_q    <= EXEC;
        end
        EXEC: begin
          rdata_q <= (we_q || err_q) ? '0 : dm_rdata;
          if (we_q && !err_q && be_q != BE_FULL && be_q != 4'h0) begin
            dm_wdata_q <= byte_merge(dm_wdata_q, dm_rdata, be_q);
            dm_we_q    <= 1'b1;
            state_q    <= MERGE_WR;
          end else begin
            rvld_q[own_q] <= 1'b1;
            state_q       <= RESP;
          end
        end
        MERGE_WR: begin
          rvld_q[own_q] <= 1'b1;
          state_q       <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy              = (state_q != IDLE);
  assign dm_mem_write      = dm_we_q;
  assign dm_wdata          = dm_wdata_q;
  assign dm_addr           = 32'({idx_q, 2'b00});
  assign bus.p0_resp_valid = rvld_q[0];
  assign bus.p1_resp_valid = rvld_q[1];
  assign bus.resp_rdata    = rdata_q;
`ifdef DMEM_CTRL_RANGE_CHK_EN
  assign bus.resp_err      = err_q & (|rvld_q);
`else
  assign bus.resp_err      = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized + directed bench for dmem_ctrl against a transaction-level memory model.
module tb_dmem_ctrl;
  localparam int DEPTH    = 64;
  localparam int RST_PRIO = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        busy, dm_mem_write;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  dmem_ctrl_if bus();

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .RESET_PRIO(RST_PRIO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .dm_mem_write(dm_mem_write),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          cyc = 0, wr_cnt = 0;
  int          n_chk = 0, n_err = 0, both_rdy = 0, rdy_busy = 0;
  logic        pre_en = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_val = '0;
  logic        ptr = 1'(RST_PRIO);
  logic [7:0]  glog = '0;
  req_t        q0[$], q1[$];

  assign dm_rdata = mem[dm_addr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_en) mem[pre_idx] <= pre_val;
    if (dm_mem_write) begin
      mem[dm_addr[7:2]] <= dm_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (bus.p0_ready && bus.p1_ready) both_rdy++;
    if ((bus.p0_ready || bus.p1_ready) && busy) rdy_busy++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic preset(input int idx, input logic [31:0] val);
    pre_idx = idx; pre_val = val; pre_en = 1'b1; ref_mem[idx] = val;
    @(posedge clk); #1 pre_en = 1'b0;
  endtask

  task automatic drive();
    bus.p0_valid = (q0.size() != 0);
    bus.p1_valid = (q1.size() != 0);
    if (q0.size() != 0) {bus.p0_we, bus.p0_addr, bus.p0_wdata, bus.p0_be} = q0[0];
    if (q1.size() != 0) {bus.p1_we, bus.p1_addr, bus.p1_wdata, bus.p1_be} = q1[0];
  endtask

  // Transaction-level memory semantics: word store with byte lanes, out-of-range rejects.
  task automatic model(input req_t r, output int lat, output logic [31:0] rd,
                       output logic err, output int nwr, output int idx);
    int unsigned word;
    logic        oor;
    word = r.addr >> 2;
    idx  = int'(word % DEPTH);
    oor  = 1'b0;
`ifdef DMEM_CTRL_RANGE_CHK_EN
    oor  = (word >= DEPTH);
`endif
    err = oor;
    rd  = (!r.we && !oor) ? ref_mem[idx] : 32'h0;
    nwr = (r.we && !oor && r.be != 4'h0) ? 1 : 0;
    lat = (nwr == 1 && r.be != 4'hF) ? 3 : 2;
    if (r.we && !oor)
      for (int b = 0; b < 4; b++) if (r.be[b]) ref_mem[idx][8*b +: 8] = r.wdata[8*b +: 8];
  endtask

  task automatic run(input int budget);
    bit          pend = 1'b0;
    int          acc_cyc = 0, lat = 0, nwr = 0, idx = 0, wr0 = 0, t0;
    logic [31:0] rd = '0;
    logic        err = 1'b0, port = 1'b0, rdy, vld, g;
    req_t        r;
    @(posedge clk); #1 drive();
    t0 = cyc;
    while ((q0.size() != 0 || q1.size() != 0 || pend) && (cyc - t0) < budget) begin
      @(negedge clk);
      rdy = bus.p0_ready | bus.p1_ready;
      vld = bus.p0_valid | bus.p1_valid;
      if (pend) chk("rdy_busy", rdy, 0);
      else if (vld) chk("rdy_idle", rdy, 1);
      if (!pend) chk("resp_idle", {bus.p1_resp_valid, bus.p0_resp_valid}, 0);
      else if (bus.p0_resp_valid || bus.p1_resp_valid) begin
        chk("resp_port", {bus.p1_resp_valid, bus.p0_resp_valid}, port ? 2 : 1);
        chk("latency", cyc - acc_cyc, lat);
        chk("rdata", bus.resp_rdata, rd);
        chk("err", bus.resp_err, err);
        chk("writes", wr_cnt - wr0, nwr);
        chk("mem_word", mem[idx], ref_mem[idx]);
        pend = 1'b0;
      end else if (cyc - acc_cyc > 3) begin
        chk("resp_timeout", cyc - acc_cyc, lat);
        pend = 1'b0;
      end
      if (rdy && !pend) begin
        g = bus.p1_ready;
        chk("grant", g, (bus.p0_valid && bus.p1_valid) ? ptr : bus.p1_valid);
        if ((g && q1.size() != 0) || (!g && q0.size() != 0)) begin
          r = g ? q1[0] : q0[0];
          model(r, lat, rd, err, nwr, idx);
          ptr = ~g; glog = {glog[6:0], g}; port = g;
          acc_cyc = cyc; wr0 = wr_cnt; pend = 1'b1;
          @(posedge clk);
          if (g) void'(q1.pop_front()); else void'(q0.pop_front());
          #1 drive();
        end
      end
    end
    chk("run_done", q0.size() + q1.size() + int'(pend), 0);
    q0.delete(); q1.delete(); drive();
  endtask

  initial begin
    req_t r;
    int   n, w, bad;
    bus.p0_valid = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0; bus.p0_be = 0;
    bus.p1_valid = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0; bus.p1_be = 0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) preset(i, $urandom);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_write", dm_mem_write, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_wdata", dm_wdata, 0);
    chk("rst_ready", {bus.p1_ready, bus.p0_ready}, 0);
    chk("rst_resp_valid", {bus.p1_resp_valid, bus.p0_resp_valid}, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_err", bus.resp_err, 0);

    // Full store then load on port 0
    preset(3, 32'h0);
    q0.push_back('{1'b1, 32'h0C, 32'hDEADBEEF, 4'hF});
    q0.push_back('{1'b0, 32'h0C, 32'h0, 4'h0});
    run(50);
    chk("word3_full", mem[3], 32'hDEADBEEF);

    // Partial store on port 1 -> read-modify-write
    preset(5, 32'h11223344);
    q1.push_back('{1'b1, 32'h14, 32'hAABBCCDD, 4'b0101});
    run(50);
    chk("word5_merge", mem[5], 32'h11BB33DD);

    // be=0 store: no write, short latency
    q0.push_back('{1'b1, 32'h20, 32'hFFFFFFFF, 4'h0});
    run(50);

    // Index past the end
    preset(0, 32'h0);
    q0.push_back('{1'b1, 32'h100, 32'h5A5A1234, 4'hF});
    run(50);
`ifdef DMEM_CTRL_RANGE_CHK_EN
    chk("oor_word0", mem[0], 32'h0);
`else
    chk("wrap_word0", mem[0], 32'h5A5A1234);
`endif

    // Reset in MERGE_WR aborts the write; port 0 wins so the pointer was moved to 1
    preset(9, 32'hCAFEF00D);
    bus.p0_we = 1'b1; bus.p0_addr = 32'h24; bus.p0_wdata = 32'h12345678;
    bus.p0_be = 4'b0011; bus.p0_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.p0_ready && n < 5) begin @(negedge clk); n++; end
    chk("abort_accept", bus.p0_ready, 1);
    @(posedge clk); #1 bus.p0_valid = 1'b0;
    @(negedge clk); chk("abort_exec_busy", busy, 1);
    @(negedge clk); chk("abort_mwr_strobe", dm_mem_write, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_strobe_clr", dm_mem_write, 0);
    chk("abort_busy_clr", busy, 0);
    chk("abort_addr_clr", dm_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ptr = 1'(RST_PRIO);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_resp", {bus.p1_resp_valid, bus.p0_resp_valid}, 0);
    end
    chk("abort_word9", mem[9], 32'hCAFEF00D);

    // Contention: alternating grants starting from the reset priority
    q0.push_back('{1'b0, 32'h0C, 32'h0, 4'h0});
    q0.push_back('{1'b0, 32'h14, 32'h0, 4'h0});
    q1.push_back('{1'b0, 32'h24, 32'h0, 4'h0});
    q1.push_back('{1'b0, 32'h04, 32'h0, 4'h0});
    run(100);
    chk("arb_seq", {28'h0, glog[3:0]}, 32'b0101);

    // Random traffic on both ports
    for (int i = 0; i < 40; i++) begin
      w       = $urandom_range(0, DEPTH + 7);
      r.we    = 1'($urandom_range(0, 1));
      r.addr  = {w[29:0], 2'($urandom_range(0, 3))};
      r.wdata = $urandom;
      n       = $urandom_range(0, 3);
      r.be    = (n == 0) ? 4'h0 : (n == 1) ? 4'hF : 4'($urandom_range(1, 14));
      if ($urandom_range(0, 1) == 1) q0.push_back(r); else q1.push_back(r);
    end
    run(600);

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", bad, 0);
    chk("both_ready", both_rdy, 0);
    chk("ready_while_busy", rdy_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
